// File: rtl/rgb_sched_pkg.sv
// Shared types, default addresses and helpers for the RGB conversion scheduler.
package rgb_sched_pkg;

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, CAP0, CAP1,
        CONV0, CONV1, CONV2, CONV3, CONV4, CONV5,
        WR0, WR1, WR2, DONE
    } sched_state_t;

    localparam logic [17:0] Y_BASE_DEF    = 18'd0;
    localparam logic [17:0] U_BASE_DEF    = 18'd38400;
    localparam logic [17:0] V_BASE_DEF    = 18'd76800;
    localparam logic [17:0] RGB_BASE_DEF  = 18'd146944;
    localparam int          NUM_PAIRS_DEF = 38400;

    localparam int SRAM_LAT    = 2;
    localparam int CONV_CYCLES = 6;

    // Three RGB words per pixel pair; the sum wraps modulo 2^18.
    function automatic logic [17:0] rgb_word_addr(input logic [17:0] base, input logic [15:0] k);
        return base + 18'(k) + 18'(k) + 18'(k);
    endfunction

endpackage

// File: rtl/rgb_conv_scheduler_if.sv
// SRAM port bundle between the scheduler (master) and the SRAM port mux (slave).
interface rgb_conv_scheduler_if;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    modport master (
        output SRAM_address,
        output SRAM_write_data,
        output SRAM_we_n,
        input  SRAM_read_data
    );

    modport slave (
        input  SRAM_address,
        input  SRAM_write_data,
        input  SRAM_we_n,
        output SRAM_read_data
    );
endinterface

// File: rtl/rgb_word_packer.sv
// Picks the 16-bit RGB word for write slot 0/1/2 out of the even/odd pixel bytes.
module rgb_word_packer (
    input  logic [1:0]  sel,
    input  logic [7:0]  r_even,
    input  logic [7:0]  g_even,
    input  logic [7:0]  b_even,
    input  logic [7:0]  r_odd,
    input  logic [7:0]  g_odd,
    input  logic [7:0]  b_odd,
    output logic [15:0] word
);

    // Slot 0 = {R0,G0}, slot 1 = {B0,R1}, slot 2 = {G1,B1}.
    always_comb begin
        word = {r_even, g_even};
        case (sel)
            2'd1:    word = {b_even, r_odd};
            2'd2:    word = {g_odd, b_odd};
            default: word = {r_even, g_even};
        endcase
    end

endmodule

// File: rtl/rgb_conv_scheduler.sv
// Sequences Y/U/V reads, the 3-phase converter and the packed RGB writes per pixel pair.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | waiting for start, k = 0
//  RD0-2  | issue Y, U, V reads for pair k (Y lands at end of RD2)
//  CAP0/1 | U and V words land
//  CONV0-2| converter enabled, even-pixel bytes on its inputs
//  CONV3-5| converter enabled, odd-pixel bytes; even R/G/B latched in CONV3
//  WR0-2  | write the three RGB words; odd R/G/B latched in WR0
//  DONE   | one-cycle done pulse, then back to IDLE
module rgb_conv_scheduler
    import rgb_sched_pkg::*;
#(
    parameter logic [17:0] Y_BASE    = Y_BASE_DEF,
    parameter logic [17:0] U_BASE    = U_BASE_DEF,
    parameter logic [17:0] V_BASE    = V_BASE_DEF,
    parameter logic [17:0] RGB_BASE  = RGB_BASE_DEF,
    parameter int          NUM_PAIRS = NUM_PAIRS_DEF
) (
    input  logic                        CLOCK_50_I,
    input  logic                        resetn,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    rgb_conv_scheduler_if.master        sram,
    output logic                        enable_RGB,
    output logic [31:0]                 Y_in_RGB,
    output logic [31:0]                 U_in_RGB,
    output logic [31:0]                 V_in_RGB,
    input  logic [7:0]                  R_buff,
    input  logic [7:0]                  G_buff,
    input  logic [7:0]                  B_buff
);

    sched_state_t state;
    logic [15:0]  k;
    logic [15:0]  y_word;
    logic [15:0]  u_word;
    logic [7:0]   v_odd;
    logic [7:0]   r0, g0, b0, r1, g1, b1;
    logic [1:0]   wr_sel;
    logic [7:0]   r_odd_src, g_odd_src, b_odd_src;
    logic [15:0]  packed_word;

    // The odd pixel's R/G/B is captured at the same edge that loads the WR1 word,
    // so during WR0 the packer takes the odd bytes straight from the converter.
    always_comb begin
        wr_sel    = 2'd0;
        r_odd_src = r1;
        g_odd_src = g1;
        b_odd_src = b1;
        if (state == WR0) begin
            wr_sel    = 2'd1;
            r_odd_src = R_buff;
            g_odd_src = G_buff;
            b_odd_src = B_buff;
        end else if (state == WR1) begin
            wr_sel = 2'd2;
        end
    end

    rgb_word_packer u_packer (
        .sel    (wr_sel),
        .r_even (r0),
        .g_even (g0),
        .b_even (b0),
        .r_odd  (r_odd_src),
        .g_odd  (g_odd_src),
        .b_odd  (b_odd_src),
        .word   (packed_word)
    );

    // Pair sequencer; every output is registered and reflects the current state.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state                <= IDLE;
            k                    <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            sram.SRAM_address    <= '0;
            sram.SRAM_write_data <= '0;
            sram.SRAM_we_n       <= 1'b1;
            enable_RGB           <= 1'b0;
            Y_in_RGB             <= '0;
            U_in_RGB             <= '0;
            V_in_RGB             <= '0;
            y_word               <= '0;
            u_word               <= '0;
            v_odd                <= '0;
            r0                   <= '0;
            g0                   <= '0;
            b0                   <= '0;
            r1                   <= '0;
            g1                   <= '0;
            b1                   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state             <= RD0;
                        busy              <= 1'b1;
                        sram.SRAM_address <= Y_BASE + 18'(k);
                    end
                end
                RD0: begin
                    state             <= RD1;
                    sram.SRAM_address <= U_BASE + 18'(k);
                end
                RD1: begin
                    state             <= RD2;
                    sram.SRAM_address <= V_BASE + 18'(k);
                end
                RD2: begin
                    state  <= CAP0;
                    y_word <= sram.SRAM_read_data;
                end
                CAP0: begin
                    state  <= CAP1;
                    u_word <= sram.SRAM_read_data;
                end
                CAP1: begin
                    // V arrives on this edge, so its even byte goes straight to the converter.
                    state      <= CONV0;
                    v_odd      <= sram.SRAM_read_data[7:0];
                    enable_RGB <= 1'b1;
                    Y_in_RGB   <= {24'd0, y_word[15:8]};
                    U_in_RGB   <= {24'd0, u_word[15:8]};
                    V_in_RGB   <= {24'd0, sram.SRAM_read_data[15:8]};
                end
                CONV0: state <= CONV1;
                CONV1: state <= CONV2;
                CONV2: begin
                    state    <= CONV3;
                    Y_in_RGB <= {24'd0, y_word[7:0]};
                    U_in_RGB <= {24'd0, u_word[7:0]};
                    V_in_RGB <= {24'd0, v_odd};
                end
                CONV3: begin
                    state <= CONV4;
                    r0    <= R_buff;
                    g0    <= G_buff;
                    b0    <= B_buff;
                end
                CONV4: state <= CONV5;
                CONV5: begin
                    state                <= WR0;
                    enable_RGB           <= 1'b0;
                    sram.SRAM_address    <= rgb_word_addr(RGB_BASE, k);
                    sram.SRAM_write_data <= packed_word;
                    sram.SRAM_we_n       <= 1'b0;
                end
                WR0: begin
                    state                <= WR1;
                    r1                   <= R_buff;
                    g1                   <= G_buff;
                    b1                   <= B_buff;
                    sram.SRAM_address    <= sram.SRAM_address + 18'd1;
                    sram.SRAM_write_data <= packed_word;
                end
                WR1: begin
                    state                <= WR2;
                    sram.SRAM_address    <= sram.SRAM_address + 18'd1;
                    sram.SRAM_write_data <= packed_word;
                end
                WR2: begin
                    sram.SRAM_we_n <= 1'b1;
                    if (k == 16'(NUM_PAIRS - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state             <= RD0;
                        k                 <= k + 16'd1;
                        sram.SRAM_address <= Y_BASE + 18'(k) + 18'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    k     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_conv_scheduler.sv
// Bench for rgb_conv_scheduler: SRAM and converter models, write/read scoreboards.
module tb_rgb_conv_scheduler;
    import rgb_sched_pkg::*;

    localparam int NP         = 2;
    localparam int RUN_BUDGET = NP * (3 + SRAM_LAT + CONV_CYCLES + 3) + 30;

    typedef struct packed {
        logic [15:0] y, u, v, w0, w1, w2;
    } vec_t;

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn     = 1'b0;
    logic        start      = 1'b0;
    logic        busy, done, enable_RGB;
    logic [31:0] Y_in_RGB, U_in_RGB, V_in_RGB;
    logic [7:0]  R_buff, G_buff, B_buff;

    rgb_conv_scheduler_if sram_bus ();

    rgb_conv_scheduler #(.NUM_PAIRS(NP)) dut (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .sram       (sram_bus),
        .enable_RGB (enable_RGB),
        .Y_in_RGB   (Y_in_RGB),
        .U_in_RGB   (U_in_RGB),
        .V_in_RGB   (V_in_RGB),
        .R_buff     (R_buff),
        .G_buff     (G_buff),
        .B_buff     (B_buff)
    );

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    vec_t        vecs [8];
    logic [15:0] y_mem [NP];
    logic [15:0] u_mem [NP];
    logic [15:0] v_mem [NP];
    wr_t         wr_q [$];
    logic [17:0] rd_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SRAM read model: address seen at an edge, data presented two edges later.
    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        int oy = int'(a) - int'(Y_BASE_DEF);
        int ou = int'(a) - int'(U_BASE_DEF);
        int ov = int'(a) - int'(V_BASE_DEF);
        if (oy >= 0 && oy < NP) return y_mem[1'(oy)];
        if (ou >= 0 && ou < NP) return u_mem[1'(ou)];
        if (ov >= 0 && ov < NP) return v_mem[1'(ov)];
        return 16'h0000;
    endfunction

    logic [15:0] rd_pipe = 16'h0;
    always @(posedge CLOCK_50_I) begin
        rd_pipe                 <= mem_rd(sram_bus.SRAM_address);
        sram_bus.SRAM_read_data <= rd_pipe;
    end

    // Converter model: 3 enabled phases per pixel, result registered on the third.
    function automatic logic [7:0] clip8(input int x);
        if (x < 0)   return 8'd0;
        if (x > 255) return 8'd255;
        return 8'(x);
    endfunction

    function automatic int conv_r(input logic [31:0] y, input logic [31:0] v);
        return (76284 * (int'(y) - 16) + 104595 * (int'(v) - 128)) >>> 16;
    endfunction

    function automatic int conv_g(input logic [31:0] y, input logic [31:0] u, input logic [31:0] v);
        return (76284 * (int'(y) - 16) - 25624 * (int'(u) - 128) - 53281 * (int'(v) - 128)) >>> 16;
    endfunction

    function automatic int conv_b(input logic [31:0] y, input logic [31:0] u);
        return (76284 * (int'(y) - 16) + 132251 * (int'(u) - 128)) >>> 16;
    endfunction

    int phase;
    always @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            phase  <= 0;
            R_buff <= 8'd0;
            G_buff <= 8'd0;
            B_buff <= 8'd0;
        end else if (enable_RGB) begin
            if (phase == 2) begin
                phase  <= 0;
                R_buff <= clip8(conv_r(Y_in_RGB, V_in_RGB));
                G_buff <= clip8(conv_g(Y_in_RGB, U_in_RGB, V_in_RGB));
                B_buff <= clip8(conv_b(Y_in_RGB, U_in_RGB));
            end else begin
                phase <= phase + 1;
            end
        end
    end

    // Monitor: pops expected writes and reads as the DUT presents them.
    logic [17:0] last_addr = '0;
    logic        last_busy = 1'b0;
    always @(negedge CLOCK_50_I) begin : mon
        wr_t         e;
        logic [17:0] ra;
        if (resetn) begin
            if (!sram_bus.SRAM_we_n) begin
                wr_count++;
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             sram_bus.SRAM_address, sram_bus.SRAM_write_data);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(sram_bus.SRAM_address), 32'(e.addr));
                    chk("wr_data", 32'(sram_bus.SRAM_write_data), 32'(e.data));
                end
            end else if (busy && (!last_busy || sram_bus.SRAM_address != last_addr)) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_read: addr 0x%0h, expected no read", sram_bus.SRAM_address);
                end else begin
                    ra = rd_q.pop_front();
                    chk("rd_addr", 32'(sram_bus.SRAM_address), 32'(ra));
                end
            end
        end
        last_addr = sram_bus.SRAM_address;
        last_busy = resetn ? busy : 1'b0;
    end

    task automatic push_pair(input int i, input vec_t v, input int nwr);
        rd_q.push_back(Y_BASE_DEF + 18'(i));
        rd_q.push_back(U_BASE_DEF + 18'(i));
        rd_q.push_back(V_BASE_DEF + 18'(i));
        if (nwr > 0) wr_q.push_back('{addr: RGB_BASE_DEF + 18'(3 * i),     data: v.w0});
        if (nwr > 1) wr_q.push_back('{addr: RGB_BASE_DEF + 18'(3 * i + 1), data: v.w1});
        if (nwr > 2) wr_q.push_back('{addr: RGB_BASE_DEF + 18'(3 * i + 2), data: v.w2});
    endtask

    task automatic run_pairs(input logic [2:0] p0, input logic [2:0] p1,
                             input bit pulse, input bit abort, input string tag);
        int done_cyc   = -1;
        int pulses     = 0;
        int busy_low   = 0;
        int busy_after = 0;
        int wr_start;
        y_mem[0] = vecs[p0].y; u_mem[0] = vecs[p0].u; v_mem[0] = vecs[p0].v;
        y_mem[1] = vecs[p1].y; u_mem[1] = vecs[p1].u; v_mem[1] = vecs[p1].v;
        if (abort) begin
            push_pair(0, vecs[p0], 1);
        end else begin
            push_pair(0, vecs[p0], 3);
            push_pair(1, vecs[p1], 3);
        end
        wr_start = wr_count;
        start = 1'b1;
        @(posedge CLOCK_50_I);
        #1 start = 1'b0;
        for (int c = 1; c <= RUN_BUDGET; c++) begin
            @(negedge CLOCK_50_I);
            if (pulse && c == 8) start = 1'b1;
            if (c == 9) start = 1'b0;
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc < 0 && !busy) busy_low++;
            if (done_cyc > 0 && c > done_cyc && busy) busy_after++;
            if (abort && c == 12) begin
                @(posedge CLOCK_50_I);
                #1 resetn = 1'b0;
                #1;
                chk({tag, "_we_n"},   32'(sram_bus.SRAM_we_n), 32'd1);
                chk({tag, "_busy"},   32'(busy), 32'd0);
                chk({tag, "_done"},   32'(done), 32'd0);
                chk({tag, "_enable"}, 32'(enable_RGB), 32'd0);
                break;
            end
        end
        if (abort) begin
            repeat (2) @(negedge CLOCK_50_I);
            resetn = 1'b1;
            pulses = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge CLOCK_50_I);
                if (done) pulses++;
                if (busy) busy_after++;
            end
            chk({tag, "_no_done"}, 32'(pulses), 32'd0);
            chk({tag, "_idle"},    32'(busy_after), 32'd0);
            chk({tag, "_writes"},  32'(wr_count - wr_start), 32'd1);
        end else begin
            chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd29);
            chk({tag, "_done_pulses"}, 32'(pulses), 32'd1);
            chk({tag, "_busy_gap"}, 32'(busy_low), 32'd0);
            chk({tag, "_busy_after"}, 32'(busy_after), 32'd0);
            chk({tag, "_writes"}, 32'(wr_count - wr_start), 32'd6);
        end
    endtask

    initial begin
        //           y         u         v         w0        w1        w2
        vecs[0] = {16'h1010, 16'h8080, 16'h8080, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = {16'hEBEB, 16'h8080, 16'h8080, 16'hFEFE, 16'hFEFE, 16'hFEFE};
        vecs[2] = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFF7D, 16'hFFFF, 16'h7DFF};
        vecs[3] = {16'h10EB, 16'h8080, 16'h8080, 16'h0000, 16'h00FE, 16'hFEFE};
        vecs[4] = {16'hFF10, 16'hFF80, 16'hFF80, 16'hFF7D, 16'hFF00, 16'h0000};
        for (int i = 5; i < 8; i++) vecs[i] = '0;

        repeat (3) @(negedge CLOCK_50_I);
        chk("rst_we_n",  32'(sram_bus.SRAM_we_n), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_addr",  32'(sram_bus.SRAM_address), 32'd0);
        chk("rst_wdata", 32'(sram_bus.SRAM_write_data), 32'd0);
        chk("rst_en",    32'(enable_RGB), 32'd0);
        chk("rst_yuv",   Y_in_RGB | U_in_RGB | V_in_RGB, 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50_I);

        run_pairs(3'd0, 3'd2, 1'b0, 1'b0, "black_clip");
        repeat (3) @(negedge CLOCK_50_I);
        run_pairs(3'd1, 3'd3, 1'b0, 1'b0, "white_mixed");
        repeat (3) @(negedge CLOCK_50_I);
        run_pairs(3'd4, 3'd0, 1'b1, 1'b0, "start_busy");
        repeat (3) @(negedge CLOCK_50_I);
        run_pairs(3'd2, 3'd3, 1'b0, 1'b1, "abort");
        repeat (3) @(negedge CLOCK_50_I);
        run_pairs(3'd4, 3'd1, 1'b0, 1'b0, "rerun");
        repeat (3) @(negedge CLOCK_50_I);

        chk("wr_queue_left", 32'(wr_q.size()), 32'd0);
        chk("rd_queue_left", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
